// File: rtl/conv_frame_ctrl_pkg.sv
// Shared types and constants for the convolution frame sequencer.
package conv_frame_ctrl_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Identity kernel: only the centre tap (r=1, c=1 -> bit 4) is set.
  localparam logic [8:0] IDENT_KERNEL = 9'h010;

  // Number of selectable coefficient banks.
  localparam int COE_SETS = 4;

endpackage

// File: rtl/conv_coe_bank.sv
// Four 9-bit coefficient banks with one write port and a combinational read.
module conv_coe_bank
  import conv_frame_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [1:0] wr_set,
  input  logic [8:0] wr_data,
  input  logic [1:0] rd_sel,
  output logic [8:0] rd_data
);

  logic [8:0] bank_q [COE_SETS];
  logic [8:0] bank_d [COE_SETS];

  // Next bank contents: a write replaces one entry, everything else holds.
  always_comb begin
    bank_d = bank_q;
    if (wr_en) begin
      bank_d[wr_set] = wr_data;
    end
  end

  // Bank storage.
  // NOTE: this small register file is reset so every bank starts as the identity
  // kernel; a large RAM would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < COE_SETS; i++) begin
        bank_q[i] <= IDENT_KERNEL;
      end
    end else begin
      bank_q <= bank_d;
    end
  end

  assign rd_data = bank_q[rd_sel];

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame-level sequencer for the 3x3 convolution engine: feeds one frame of
// pixels, drains the engine with dummy pixels and forwards valid results.
module conv_frame_ctrl
  import conv_frame_ctrl_pkg::*;
#(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int FLUSH_MAX = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  coe_sel,
  input  logic        coe_wr_en,
  input  logic [1:0]  coe_wr_set,
  input  logic [8:0]  coe_wr_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [15:0] s_data,
  output logic [15:0] conv_data_in,
  output logic        conv_data_in_en,
  output logic [8:0]  conv_coe,
  input  logic [15:0] conv_data_out,
  input  logic        conv_data_out_en,
  output logic        m_valid,
  output logic [15:0] m_data,
  output logic        busy,
  output logic        done,
  output logic        err_timeout
);

  localparam int OUT_N   = (IMG_W - 2) * (IMG_H - 2);
  localparam int COL_W   = $clog2(IMG_W);
  localparam int ROW_W   = $clog2(IMG_H);
  localparam int OUT_W   = $clog2(OUT_N + 1);
  localparam int FLUSH_W = $clog2(FLUSH_MAX + 1);

  localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [OUT_W-1:0]   OUT_LAST  = OUT_W'(OUT_N);
  localparam logic [FLUSH_W-1:0] FLUSH_LIM = FLUSH_W'(FLUSH_MAX);

  state_e              state_q,      state_d;
  logic [COL_W-1:0]    col_cnt_q,    col_cnt_d;
  logic [ROW_W-1:0]    row_cnt_q,    row_cnt_d;
  logic [OUT_W-1:0]    out_cnt_q,    out_cnt_d;
  logic [FLUSH_W-1:0]  flush_cnt_q,  flush_cnt_d;
  logic [8:0]          coe_active_q, coe_active_d;
  logic                err_q,        err_d;
  logic                m_valid_q,    m_valid_d;
  logic [15:0]         m_data_q,     m_data_d;

  logic       bank_wr_en;
  logic [8:0] bank_rd_data;
  logic       in_xfer;
  logic       result_window;

  // Banks are only writable while no frame is in flight, so a frame never
  // sees its kernel change underneath it.
  assign bank_wr_en = coe_wr_en && (state_q == ST_IDLE);

  conv_coe_bank u_coe_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bank_wr_en),
    .wr_set  (coe_wr_set),
    .wr_data (coe_wr_data),
    .rd_sel  (coe_sel),
    .rd_data (bank_rd_data)
  );

  assign in_xfer       = s_valid && (state_q == ST_RUN);
  assign result_window = (state_q == ST_RUN) || (state_q == ST_FLUSH);

  // Next-state, counter, coefficient latch and result-gating logic.
  // NOTE: every variable gets a default at the top so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    out_cnt_d    = out_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    coe_active_d = coe_active_q;
    err_d        = err_q;
    m_valid_d    = 1'b0;
    m_data_d     = m_data_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        coe_active_d = bank_rd_data;
        col_cnt_d    = '0;
        row_cnt_d    = '0;
        out_cnt_d    = '0;
        flush_cnt_d  = '0;
        state_d      = ST_RUN;
      end
      ST_RUN: begin
        if (in_xfer) begin
          if (col_cnt_q == COL_LAST) begin
            col_cnt_d = '0;
            if (row_cnt_q == ROW_LAST) begin
              row_cnt_d = '0;
              state_d   = ST_FLUSH;
            end else begin
              row_cnt_d = row_cnt_q + ROW_W'(1);
            end
          end else begin
            col_cnt_d = col_cnt_q + COL_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q != FLUSH_LIM) begin
          flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
        end
        // A complete result set wins over a coincident timeout.
        if (out_cnt_q == OUT_LAST) begin
          state_d = ST_DONE;
        end else if (flush_cnt_q == FLUSH_LIM) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Forward engine results only while a frame is active and the frame still
    // owes results; the surplus a drained pipeline produces is dropped.
    if (result_window && conv_data_out_en && (out_cnt_q < OUT_LAST)) begin
      m_valid_d = 1'b1;
      m_data_d  = conv_data_out;
      out_cnt_d = out_cnt_q + OUT_W'(1);
    end

    // Abort overrides every other transition and discards the frame.
    if (abort && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      m_valid_d   = 1'b0;
      col_cnt_d   = '0;
      row_cnt_d   = '0;
      out_cnt_d   = '0;
      flush_cnt_d = '0;
    end
  end

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from the values computed in the combinational block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      out_cnt_q    <= '0;
      flush_cnt_q  <= '0;
      coe_active_q <= IDENT_KERNEL;
      err_q        <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
    end else begin
      state_q      <= state_d;
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      out_cnt_q    <= out_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      coe_active_q <= coe_active_d;
      err_q        <= err_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
    end
  end

  // Pixel path to the engine: pass-through in RUN, zero dummies in FLUSH.
  always_comb begin
    s_ready         = 1'b0;
    conv_data_in    = '0;
    conv_data_in_en = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        s_ready         = 1'b1;
        conv_data_in    = s_data;
        conv_data_in_en = s_valid;
      end
      ST_FLUSH: begin
        conv_data_in_en = 1'b1;
      end
      default: begin
        s_ready = 1'b0;
      end
    endcase
  end

  assign conv_coe    = coe_active_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl on a 4x4 frame with an 8-cycle
// flush limit, using a behavioural 3x3 convolution engine model.
module tb_conv_frame_ctrl;

  localparam int W      = 4;
  localparam int H      = 4;
  localparam int FMAX   = 8;
  localparam int IMG_N  = W * H;
  localparam int OUT_N  = (W - 2) * (H - 2);
  localparam int LAT    = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [1:0]  coe_sel;
  logic        coe_wr_en;
  logic [1:0]  coe_wr_set;
  logic [8:0]  coe_wr_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic [15:0] conv_data_in;
  logic        conv_data_in_en;
  logic [8:0]  conv_coe;
  logic [15:0] conv_data_out;
  logic        conv_data_out_en;
  logic        m_valid;
  logic [15:0] m_data;
  logic        busy, done, err_timeout;

  conv_frame_ctrl #(.IMG_W(W), .IMG_H(H), .FLUSH_MAX(FMAX)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .abort            (abort),
    .coe_sel          (coe_sel),
    .coe_wr_en        (coe_wr_en),
    .coe_wr_set       (coe_wr_set),
    .coe_wr_data      (coe_wr_data),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_data           (s_data),
    .conv_data_in     (conv_data_in),
    .conv_data_in_en  (conv_data_in_en),
    .conv_coe         (conv_coe),
    .conv_data_out    (conv_data_out),
    .conv_data_out_en (conv_data_out_en),
    .m_valid          (m_valid),
    .m_data           (m_data),
    .busy             (busy),
    .done             (done),
    .err_timeout      (err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference state: bank contents and the running frame's bookkeeping.
  logic [8:0]  bank_m [4];
  logic [8:0]  exp_coe;
  int          n_res_g;
  logic [15:0] pix [IMG_N];
  int          acc_cnt, win_cnt, ready_cnt, flush_obs, done_cnt, done_cyc;
  int          sched_cyc [$];
  logic [15:0] sched_val [$];
  int          emit_cyc [$];
  logic [15:0] emit_val [$];
  int          m_cyc [$];
  logic [15:0] m_val [$];
  logic        o_busy, o_ready, o_err;
  logic [8:0]  o_coe;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Valid-window convolution of the 3x3 neighbourhood ending at (r, c).
  function automatic logic [15:0] win_sum(input int r, input int c, input logic [8:0] coe);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (coe[i*3+j]) s = s + pix[(r - 2 + i) * W + (c - 2 + j)];
    return s;
  endfunction

  // One clock cycle: drive the engine model, observe, then advance.
  task automatic step();
    int idx;
    conv_data_out_en = 1'b0;
    conv_data_out    = '0;
    if (sched_cyc.size() > 0 && sched_cyc[0] == cyc) begin
      conv_data_out_en = 1'b1;
      conv_data_out    = sched_val[0];
      emit_cyc.push_back(cyc);
      emit_val.push_back(sched_val[0]);
      void'(sched_cyc.pop_front());
      void'(sched_val.pop_front());
    end
    #1;
    o_busy = busy; o_ready = s_ready; o_err = err_timeout; o_coe = conv_coe;
    if (m_valid) begin
      m_cyc.push_back(cyc);
      m_val.push_back(m_data);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (s_ready) begin
      ready_cnt++;
      check("in_en_mirrors_valid", conv_data_in_en, s_valid);
      if (s_valid && acc_cnt < IMG_N) begin
        check("in_data_pass", conv_data_in, s_data);
        idx = acc_cnt;
        pix[idx] = s_data;
        acc_cnt++;
        if (idx / W >= 2 && idx % W >= 2) begin
          if (win_cnt < n_res_g) begin
            sched_cyc.push_back(cyc + LAT);
            sched_val.push_back(win_sum(idx / W, idx % W, exp_coe));
          end
          win_cnt++;
          if (win_cnt == OUT_N && n_res_g > OUT_N)
            for (int e = 0; e < n_res_g - OUT_N; e++) begin
              sched_cyc.push_back(cyc + LAT + 1 + e);
              sched_val.push_back(16'($urandom));
            end
        end
      end
    end else if (busy && conv_data_in_en) begin
      flush_obs++;
      check("flush_dummy_zero", conv_data_in, 16'h0);
    end
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic wr_bank(input logic [1:0] set, input logic [8:0] data);
    coe_wr_en = 1'b1; coe_wr_set = set; coe_wr_data = data;
    step();
    coe_wr_en = 1'b0;
    bank_m[set] = data;
  endtask

  // vmode: 0 random valid, 1 toggling valid, 2 valid always high.
  task automatic run_frame(input logic [1:0] sel, input int n_res, input int vmode,
                           input int abort_after, input bit ones, input bit poke);
    int k;
    int n_lim;
    acc_cnt = 0; win_cnt = 0; ready_cnt = 0; flush_obs = 0; done_cnt = 0; done_cyc = -1;
    sched_cyc.delete(); sched_val.delete(); emit_cyc.delete(); emit_val.delete();
    m_cyc.delete(); m_val.delete();
    exp_coe = bank_m[sel];
    n_res_g = n_res;
    n_lim   = (n_res < OUT_N) ? n_res : OUT_N;

    coe_sel = sel; start = 1'b1;
    step();
    start = 1'b0;
    check("idle_before_load", o_busy, 1'b0);
    step();
    check("load_busy", o_busy, 1'b1);
    check("load_not_ready", o_ready, 1'b0);
    check("load_err_cleared", o_err, 1'b0);

    k = 0;
    while (acc_cnt < IMG_N && k < 200) begin
      if (abort_after > 0 && acc_cnt == abort_after) break;
      case (vmode)
        0:       s_valid = 1'($urandom_range(0, 1));
        1:       s_valid = (k % 2 == 0);
        default: s_valid = 1'b1;
      endcase
      s_data = ones ? 16'd1 : 16'($urandom);
      if (poke && k == 3) begin
        coe_wr_en = 1'b1; coe_wr_set = 2'd2; coe_wr_data = 9'h0AA; start = 1'b1;
      end
      step();
      coe_wr_en = 1'b0; start = 1'b0;
      if (k == 0) begin
        check("run_ready_at_t2", o_ready, 1'b1);
        check("coe_after_load", o_coe, exp_coe);
      end
      k++;
    end
    s_valid = 1'b0;

    if (abort_after > 0) begin
      check("abort_pixels", acc_cnt, abort_after);
      abort = 1'b1;
      step();
      abort = 1'b0;
      sched_cyc.delete(); sched_val.delete();
      step();
      check("abort_idle_busy", o_busy, 1'b0);
      check("abort_idle_ready", o_ready, 1'b0);
      for (int i = 0; i < 5; i++) step();
      check("abort_no_done", done_cnt, 0);
      check("abort_no_result", m_cyc.size(), 0);
      return;
    end

    k = 0;
    while (done_cnt == 0 && k < 60) begin
      step();
      k++;
    end
    for (int i = 0; i < 3; i++) step();

    check("pixels_accepted", acc_cnt, IMG_N);
    if (vmode == 2) check("ready_cycles", ready_cnt, IMG_N);
    check("result_count", m_cyc.size(), n_lim);
    for (int i = 0; i < n_lim && i < m_cyc.size() && i < emit_cyc.size(); i++) begin
      check("result_data", m_val[i], emit_val[i]);
      check("result_latency", m_cyc[i], emit_cyc[i] + 1);
    end
    check("done_once", done_cnt, 1);
    if (n_res >= OUT_N && m_cyc.size() >= OUT_N)
      check("done_after_last", done_cyc, m_cyc[OUT_N-1] + 1);
    check("err_timeout", o_err, (n_res < OUT_N));
    if (n_res < OUT_N)
      check("flush_len", (flush_obs >= FMAX && flush_obs <= FMAX + 1), 1'b1);
    check("idle_after_done", o_busy, 1'b0);
    check("coe_stable", o_coe, exp_coe);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; coe_sel = '0;
    coe_wr_en = 1'b0; coe_wr_set = '0; coe_wr_data = '0;
    s_valid = 1'b0; s_data = '0; conv_data_out = '0; conv_data_out_en = 1'b0;
    for (int i = 0; i < 4; i++) bank_m[i] = 9'h010;
    n_res_g = 0; exp_coe = 9'h010;

    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", s_ready, 1'b0);
    check("rst_in_en", conv_data_in_en, 1'b0);
    check("rst_in_data", conv_data_in, 16'h0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err_timeout, 1'b0);
    check("rst_coe", conv_coe, 9'h010);
    rst_n = 1'b1;

    wr_bank(2'd0, 9'h1FF);
    run_frame(2'd0, 4, 2, 0, 1'b1, 1'b0);
    check("ones_result_9", (m_val.size() > 0) ? m_val[0] : 16'hFFFF, 16'd9);
    run_frame(2'd0, 4, 1, 0, 1'b0, 1'b0);
    run_frame(2'd0, 6, 0, 0, 1'b0, 1'b0);
    run_frame(2'd0, 2, 0, 0, 1'b0, 1'b0);
    run_frame(2'd0, 4, 0, 0, 1'b0, 1'b0);
    run_frame(2'd0, 4, 0, 5, 1'b0, 1'b0);
    run_frame(2'd0, 4, 0, 0, 1'b0, 1'b0);
    run_frame(2'd1, 4, 2, 0, 1'b0, 1'b1);
    run_frame(2'd2, 4, 0, 0, 1'b0, 1'b0);
    wr_bank(2'd2, 9'h0AA);
    run_frame(2'd2, 4, 0, 0, 1'b0, 1'b0);
    wr_bank(2'd1, 9'($urandom));
    run_frame(2'd1, 4, 0, 0, 1'b0, 1'b0);
    run_frame(2'd3, 2, 2, 0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a frame.
    coe_sel = 2'd2; start = 1'b1;
    step();
    start = 1'b0; s_valid = 1'b1;
    repeat (4) step();
    s_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_ready", s_ready, 1'b0);
    check("arst_err", err_timeout, 1'b0);
    check("arst_coe", conv_coe, 9'h010);
    @(negedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) bank_m[i] = 9'h010;
    run_frame(2'd0, 4, 0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
